// File: rtl/store_buffer.sv
// store_buffer: FIFO of pending 64-bit stores between the CPU memory stage and Data_Memory.
// Loads take the memory port ahead of draining stores. A load whose bytes overlap a
// buffered store is resolved against the youngest overlapping entry.
// Optional macro STB_FORWARD_EN: when defined, an exact-address hit is forwarded from
// the buffer. When undefined, any overlap stalls the load until the entry drains.
// Ports:
//   clock, reset                   rising-edge clock, async active-high reset
//   st_valid/st_addr/st_data       store request; st_ready = ~full
//   ld_valid/ld_addr               load request
//   ld_data/ld_stall               load result (same cycle) / hold-and-retry
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata   Data_Memory port
//   count/empty/full               occupancy
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_stall,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];
    logic [PW-1:0] head, tail, idx;
    logic [AW-1:0] d_fwd, d_bwd;
    logic          ovl, enq, drain;
`ifdef STB_FORWARD_EN
    logic          exact;
    logic [DW-1:0] fwd_data;
`endif

    // Walk oldest to youngest so the last overlapping entry seen is the youngest.
    always_comb begin
        ovl = 1'b0;
        idx = head;
        d_fwd = '0;
        d_bwd = '0;
`ifdef STB_FORWARD_EN
        exact = 1'b0;
        fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            d_fwd = ld_addr - ent_addr[idx];
            d_bwd = ent_addr[idx] - ld_addr;
            if (CW'(i) < count && (d_fwd < AW'(8) || d_bwd < AW'(8))) begin
                ovl = 1'b1;
`ifdef STB_FORWARD_EN
                exact = ent_addr[idx] == ld_addr;
                fwd_data = ent_data[idx];
`endif
            end
        end
    end

    assign mem_read = ld_valid & ~ovl;
`ifdef STB_FORWARD_EN
    assign ld_stall = ld_valid & ovl & ~exact;
    assign ld_data  = (ld_valid & ovl & exact) ? fwd_data : (mem_read ? mem_rdata : '0);
`else
    assign ld_stall = ld_valid & ovl;
    assign ld_data  = mem_read ? mem_rdata : '0;
`endif

    assign empty     = count == '0;
    assign full      = count == CW'(DEPTH);
    assign st_ready  = ~full;
    assign enq       = st_valid & ~full;
    // A stalled or forwarded load leaves the port free, so drain only yields to mem_read.
    assign drain     = ~empty & ~mem_read;
    assign mem_write = drain;
    assign mem_addr  = mem_read ? ld_addr : ent_addr[head];
    assign mem_wdata = ent_data[head];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            count <= count + CW'(enq) - CW'(drain);
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer with a byte-wide big-endian Data_Memory model.
module tb_store_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic        st_valid, st_ready, ld_valid, ld_stall;
    logic [63:0] st_addr, st_data, ld_addr, ld_data;
    logic        mem_read, mem_write;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  count;
    logic        empty, full;
    logic        mem_clear;
    logic [7:0]  mem [256];
    int          n_checks = 0;
    int          n_fail = 0;

    store_buffer dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] rd(input logic [7:0] a);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[63-8*k -: 8] = mem[a + 8'(k)];
        return r;
    endfunction

    always_comb mem_rdata = rd(mem_addr[7:0]);

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
        end else if (mem_write) begin
            for (int k = 0; k < 8; k++) mem[mem_addr[7:0] + 8'(k)] <= mem_wdata[63-8*k -: 8];
        end
    end

    task automatic test_reset();
        #1;
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if ({empty, full, st_ready, mem_write, mem_read, ld_stall} !== 6'b101000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 101000", {empty, full, st_ready, mem_write, mem_read, ld_stall});
        end
        n_checks++;
        if (ld_data !== 64'h0) begin n_fail++; $display("FAIL reset_ld_data: got %h expected 0", ld_data); end
    endtask

    task automatic test_store_drain();
        @(negedge clock);
        st_valid = 1; st_addr = 64'd40; st_data = 64'h5555_5555_5555_5555; ld_valid = 0;
        #1;
        n_checks++;
        if ({st_ready, mem_write} !== 2'b10) begin n_fail++; $display("FAIL enq_accept: got %b expected 10", {st_ready, mem_write}); end
        @(negedge clock);
        st_valid = 0;
        #1;
        n_checks++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL enq_count: got %0d expected 1", count); end
        n_checks++;
        if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 64'd40, 64'h5555_5555_5555_5555}) begin
            n_fail++; $display("FAIL drain_port: got %b %h %h expected 1 28 5555555555555555", mem_write, mem_addr, mem_wdata);
        end
        @(negedge clock);
        #1;
        n_checks++;
        if ({count, empty} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL drain_empty: got %0d %b expected 0 1", count, empty); end
        n_checks++;
        if (rd(8'd40) !== 64'h5555_5555_5555_5555) begin n_fail++; $display("FAIL drain_mem: got %h expected 5555555555555555", rd(8'd40)); end
    endtask

    task automatic test_forward();
        @(negedge clock);
        st_valid = 1; st_addr = 64'd80; st_data = 64'h0123_4567_89AB_CDEF; ld_valid = 0;
        @(negedge clock);
        st_valid = 0; ld_valid = 1; ld_addr = 64'd80;
        #1;
        n_checks++;
`ifdef STB_FORWARD_EN
        if ({ld_stall, mem_read, ld_data} !== {2'b00, 64'h0123_4567_89AB_CDEF}) begin
            n_fail++; $display("FAIL fwd_hit: got %b %b %h expected 0 0 0123456789abcdef", ld_stall, mem_read, ld_data);
        end
`else
        if ({ld_stall, mem_read, ld_data} !== {2'b10, 64'h0}) begin
            n_fail++; $display("FAIL fwd_hit_stall: got %b %b %h expected 1 0 0", ld_stall, mem_read, ld_data);
        end
`endif
        n_checks++;
        if ({mem_write, mem_addr} !== {1'b1, 64'd80}) begin n_fail++; $display("FAIL fwd_drain: got %b %h expected 1 50", mem_write, mem_addr); end
        @(negedge clock);
        #1;
        n_checks++;
        if ({ld_stall, mem_read, mem_addr, ld_data} !== {2'b01, 64'd80, 64'h0123_4567_89AB_CDEF}) begin
            n_fail++; $display("FAIL fwd_after: got %b %b %h %h expected 0 1 50 0123456789abcdef", ld_stall, mem_read, mem_addr, ld_data);
        end
        ld_valid = 0;
    endtask

    task automatic test_youngest();
        @(negedge clock);
        st_valid = 1; st_addr = 64'd80; st_data = 64'h1111_1111_1111_1111; ld_valid = 1; ld_addr = 64'd200;
        #1;
        n_checks++;
        if ({mem_read, mem_write} !== 2'b10) begin n_fail++; $display("FAIL young_ld_port: got %b expected 10", {mem_read, mem_write}); end
        @(negedge clock);
        st_data = 64'h2222_2222_2222_2222;
        #1;
        n_checks++;
        if ({count, mem_write} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL young_block: got %0d %b expected 1 0", count, mem_write); end
        @(negedge clock);
        st_valid = 0; ld_addr = 64'd80;
        #1;
        n_checks++;
`ifdef STB_FORWARD_EN
        if ({ld_stall, ld_data} !== {1'b0, 64'h2222_2222_2222_2222}) begin
            n_fail++; $display("FAIL young_fwd: got %b %h expected 0 2222222222222222", ld_stall, ld_data);
        end
`else
        if ({ld_stall, ld_data} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL young_stall: got %b %h expected 1 0", ld_stall, ld_data); end
`endif
        n_checks++;
        if ({count, mem_write, mem_wdata} !== {3'd2, 1'b1, 64'h1111_1111_1111_1111}) begin
            n_fail++; $display("FAIL young_drain_oldest: got %0d %b %h expected 2 1 1111111111111111", count, mem_write, mem_wdata);
        end
        for (int n = 0; n < 8 && ld_stall; n++) begin @(negedge clock); #1; end
        n_checks++;
        if ({ld_stall, ld_data} !== {1'b0, 64'h2222_2222_2222_2222}) begin
            n_fail++; $display("FAIL young_value: got %b %h expected 0 2222222222222222", ld_stall, ld_data);
        end
        ld_valid = 0;
        for (int n = 0; n < 8 && !empty; n++) begin @(negedge clock); #1; end
        n_checks++;
        if ({empty, rd(8'd80)} !== {1'b1, 64'h2222_2222_2222_2222}) begin
            n_fail++; $display("FAIL young_mem: got %b %h expected 1 2222222222222222", empty, rd(8'd80));
        end
    endtask

    task automatic test_partial();
        @(negedge clock);
        st_valid = 1; st_addr = 64'd44; st_data = 64'hA1A2_A3A4_A5A6_A7A8; ld_valid = 0;
        @(negedge clock);
        st_valid = 0; ld_valid = 1; ld_addr = 64'd40;
        #1;
        n_checks++;
        if ({ld_stall, mem_read, ld_data} !== {2'b10, 64'h0}) begin
            n_fail++; $display("FAIL part_stall: got %b %b %h expected 1 0 0", ld_stall, mem_read, ld_data);
        end
        n_checks++;
        if ({mem_write, mem_addr} !== {1'b1, 64'd44}) begin n_fail++; $display("FAIL part_drain: got %b %h expected 1 2c", mem_write, mem_addr); end
        @(negedge clock);
        #1;
        n_checks++;
        if ({ld_stall, mem_read, mem_addr, ld_data} !== {2'b01, 64'd40, 64'h5555_5555_A1A2_A3A4}) begin
            n_fail++; $display("FAIL part_read: got %b %b %h %h expected 0 1 28 55555555a1a2a3a4", ld_stall, mem_read, mem_addr, ld_data);
        end
        ld_valid = 0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            st_valid = 1; st_addr = 64'd100 + 64'(8 * i); st_data = 64'h1000 + 64'(i); ld_valid = 1; ld_addr = 64'd0;
            #1;
            n_checks++;
            if ({mem_write, st_ready} !== 2'b01) begin n_fail++; $display("FAIL fill_%0d: got %b expected 01", i, {mem_write, st_ready}); end
        end
        @(negedge clock);
        st_addr = 64'd132; st_data = 64'hDEAD;
        #1;
        n_checks++;
        if ({count, full, st_ready, mem_write, mem_read} !== {3'd4, 4'b1001}) begin
            n_fail++; $display("FAIL full_state: got %0d %b expected 4 1001", count, {full, st_ready, mem_write, mem_read});
        end
        @(negedge clock);
        ld_valid = 0;
        #1;
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL full_reject: got %0d expected 4", count); end
        n_checks++;
        if ({mem_write, mem_addr, st_ready} !== {1'b1, 64'd100, 1'b0}) begin
            n_fail++; $display("FAIL full_drain: got %b %h %b expected 1 64 0", mem_write, mem_addr, st_ready);
        end
        @(negedge clock);
        #1;
        n_checks++;
        if ({count, st_ready, mem_addr} !== {3'd3, 1'b1, 64'd108}) begin
            n_fail++; $display("FAIL after_drain: got %0d %b %h expected 3 1 6c", count, st_ready, mem_addr);
        end
        @(negedge clock);
        st_valid = 0;
        #1;
        n_checks++;
        if ({count, mem_addr} !== {3'd3, 64'd116}) begin n_fail++; $display("FAIL enq_and_drain: got %0d %h expected 3 74", count, mem_addr); end
    endtask

    task automatic test_reset_mid();
        reset = 1;
        #1;
        n_checks++;
        if ({count, empty, mem_write, st_ready} !== {3'd0, 3'b101}) begin
            n_fail++; $display("FAIL async_reset: got %0d %b expected 0 101", count, {empty, mem_write, st_ready});
        end
        @(negedge clock);
        reset = 0;
        #1;
        n_checks++;
        if ({empty, mem_write} !== 2'b10) begin n_fail++; $display("FAIL reset_idle: got %b expected 10", {empty, mem_write}); end
        n_checks++;
        if ({rd(8'd100), rd(8'd108)} !== {64'h1000, 64'h1001}) begin
            n_fail++; $display("FAIL reset_committed: got %h %h expected 1000 1001", rd(8'd100), rd(8'd108));
        end
        n_checks++;
        if ({rd(8'd116), rd(8'd124), rd(8'd132)} !== 192'h0) begin
            n_fail++; $display("FAIL reset_discarded: got %h %h %h expected 0 0 0", rd(8'd116), rd(8'd124), rd(8'd132));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1; mem_clear = 1;
        st_valid = 0; st_addr = '0; st_data = '0; ld_valid = 0; ld_addr = '0;
        repeat (2) @(negedge clock);
        reset = 0; mem_clear = 0;
        test_reset();
        test_store_drain();
        test_forward();
        test_youngest();
        test_partial();
        test_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
